rd_sdram: RTL and testbench
===========================

Name: rd_sdram

Overview:
- Read-side companion to the video write path. Fetches stored PAL lines from SDRAM as burst reads and pushes the returned words into the display output FIFO.
- Uses the same layout as the write side: each line is 3 bursts of 256 words plus 1 burst of 32 words (800 words per line). Each burst occupies one 256-word SDRAM row. Addresses are {row, 8'b0}.
- Sits between the SDRAM controller read port and the output-timing FIFO. Restarts on every frame boundary.

Parameters:
- FIFO_DEPTH, 512, output FIFO depth in words.
- LONG_LEN, 256, length of bursts 1-3 of each line.
- SHORT_LEN, 32, length of burst 4 (last) of each line.
- LINES_PER_FRAME, 288, lines fetched before the block stops and waits for the next frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vs_neg  in  1  single-cycle frame-start pulse, synchronous to clk.
- field  in  1  current field; used only with RD_FIELD_OFFSET_EN.
- wrusedw_fifo  in  9  output FIFO fill level in words.
- wr_en_fifo  out  1  output FIFO write strobe.
- fifo_data  out  16  output FIFO write data.
- rd_req  out  1  burst read request to the SDRAM controller.
- rd_ack  in  1  controller accepts the request; single-cycle pulse.
- rd_data_valid  in  1  controller read data is valid this cycle.
- sdram_data  in  16  controller read data.
- burst_length  out  9  words in the current burst.
- burst_address  out  22  start word address of the current burst.
- frame_done  out  1  all lines of the frame have been fetched.

Behaviour:
- Reset values: rd_req=0, wr_en_fifo=0, fifo_data=0, burst_length=0, burst_address=0, frame_done=0. Internal state: row=0, burst_cnt=0, line_cnt=0, restart_pending=0, state=IDLE.
- States: IDLE, RD_REQ, BURST, STATE_NOP, FRAME_DONE (one-hot).
- IDLE:
  - Next length len = SHORT_LEN if burst_cnt==3, else LONG_LEN.
  - Free space = FIFO_DEPTH - wrusedw_fifo, computed at 10 bits.
  - If restart_pending==0 and free >= len: load burst_length=len and burst_address={row,8'b0}, set rd_req=1, go to RD_REQ.
  - Otherwise stay in IDLE.
- RD_REQ:
  - rd_req, burst_length and burst_address stay stable until rd_ack.
  - On rd_ack: rd_req=0, go to BURST.
- BURST:
  - A remaining-word counter is loaded with burst_length when entering BURST.
  - Each cycle with rd_data_valid=1 decrements the counter.
  - Gaps in rd_data_valid are legal; no timeout.
  - When the counter is 1 and rd_data_valid=1, go to STATE_NOP.
  - rd_data_valid outside BURST is ignored.
- Data path: wr_en_fifo and fifo_data are registered, exactly 1 cycle after rd_data_valid/sdram_data in BURST. The number of FIFO writes per burst equals burst_length exactly.
- STATE_NOP:
  - row increments by 1, wrapping at 14 bits.
  - burst_cnt advances 0→1→2→3→0.
  - On the 3→0 wrap, line_cnt increments.
  - If line_cnt reaches LINES_PER_FRAME, go to FRAME_DONE and set frame_done=1. Otherwise go to IDLE.
- FRAME_DONE: no requests are issued; wait for restart.
- Restart: applied when vs_neg=1, or when restart_pending=1, while in IDLE, STATE_NOP or FRAME_DONE. It sets row=0, burst_cnt=0, line_cnt=0, frame_done=0, restart_pending=0, state=IDLE. In STATE_NOP, restart overrides the normal counter updates.
- vs_neg in RD_REQ or BURST: sets restart_pending=1 and does not abort. The request/burst completes normally and all its data is written to the FIFO. Restart is then applied in STATE_NOP.
- vs_neg in the same cycle as rd_ack: the burst still proceeds; restart is deferred to STATE_NOP.
- Reset mid-burst: immediate return to reset values. The controller is responsible for its own burst abort.
- The fill threshold prevents FIFO overflow, given that the FIFO is not otherwise written.

Optional Feature:
- Macro: RD_FIELD_OFFSET_EN.
- Defined: burst_address = {row,8'b0} + 22'h200000 when field==0, and {row,8'b0} when field==1. field is sampled at the IDLE→RD_REQ transition.
- Undefined: field is ignored; burst_address = {row,8'b0}.

Test Plan:
- Reset asserted mid-BURST → all outputs 0 on the next edge. After release, wrusedw_fifo=0 → rd_req=1, burst_address=0, burst_length=256.
- Full line with wrusedw_fifo=0 and immediate ack with continuous valid → bursts of 256/256/256/32 at addresses 0x000000/0x000100/0x000200/0x000300; 800 FIFO writes, each 1 cycle after its valid.
- Backpressure: wrusedw_fifo=300 before a long burst → no rd_req. At burst_cnt==3 with wrusedw_fifo=480 (free 32) → rd_req=1 with length 32.
- Valid with random gaps over a 256-word burst → exactly 256 wr_en_fifo pulses, data order preserved, then STATE_NOP.
- vs_neg at word 100 of a burst → remaining 156 words still written. Next request at address 0 with length 256.
- LINES_PER_FRAME=2 → 8 bursts, then frame_done=1 and no rd_req for 1000 cycles. vs_neg → frame_done=0 and a request at address 0. With RD_FIELD_OFFSET_EN and field=0 → address 0x200000.

Source files
------------

// File: rtl/rd_sdram.sv
// Read-side SDRAM fetcher: pulls PAL lines as burst reads and pushes the returned words into the display FIFO.
// Optional macro RD_FIELD_OFFSET_EN selects the upper 2M-word half of SDRAM for field 0.
//
// state      | meaning
// IDLE       | wait for FIFO room for the next burst (or apply a pending restart)
// RD_REQ     | request held stable until the controller acks
// BURST      | count returned words; forward each to the FIFO one cycle later
// STATE_NOP  | advance row/burst/line counters, or restart if a frame boundary arrived
// FRAME_DONE | all lines fetched; idle until the next frame start
module rd_sdram #(
    parameter int FIFO_DEPTH      = 512,
    parameter int LONG_LEN        = 256,
    parameter int SHORT_LEN       = 32,
    parameter int LINES_PER_FRAME = 288
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vs_neg,
    input  logic        field,
    input  logic [8:0]  wrusedw_fifo,
    output logic        wr_en_fifo,
    output logic [15:0] fifo_data,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic        rd_data_valid,
    input  logic [15:0] sdram_data,
    output logic [8:0]  burst_length,
    output logic [21:0] burst_address,
    output logic        frame_done
);

    localparam logic [9:0] DEPTH_W = FIFO_DEPTH[9:0];
    localparam logic [8:0] LONG_W  = LONG_LEN[8:0];
    localparam logic [8:0] SHORT_W = SHORT_LEN[8:0];
    localparam logic [8:0] LPF_W   = LINES_PER_FRAME[8:0];

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        RD_REQ     = 5'b00010,
        BURST      = 5'b00100,
        STATE_NOP  = 5'b01000,
        FRAME_DONE = 5'b10000
    } state_t;

    state_t      state;
    logic [13:0] row;
    logic [1:0]  burst_cnt;
    logic [8:0]  line_cnt;
    logic        restart_pending;
    logic [8:0]  remaining;

    logic [8:0]  next_len;
    logic [9:0]  free_space;
    logic        restart;
    logic        restart_ok;
    logic [21:0] req_addr;

    assign next_len   = (burst_cnt == 2'd3) ? SHORT_W : LONG_W;
    assign free_space = DEPTH_W - {1'b0, wrusedw_fifo};
    assign restart    = vs_neg | restart_pending;
    // Restart is only safe between bursts; mid-request it is deferred.
    assign restart_ok = (state == IDLE) || (state == STATE_NOP) || (state == FRAME_DONE);

`ifdef RD_FIELD_OFFSET_EN
    assign req_addr = field ? {row, 8'h00} : ({row, 8'h00} + 22'h200000);
`else
    logic field_unused;
    assign field_unused = field;
    assign req_addr     = {row, 8'h00};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            row             <= '0;
            burst_cnt       <= '0;
            line_cnt        <= '0;
            restart_pending <= 1'b0;
            remaining       <= '0;
            rd_req          <= 1'b0;
            wr_en_fifo      <= 1'b0;
            fifo_data       <= '0;
            burst_length    <= '0;
            burst_address   <= '0;
            frame_done      <= 1'b0;
        end else begin
            wr_en_fifo <= 1'b0;
            if (state == BURST && rd_data_valid) begin
                wr_en_fifo <= 1'b1;
                fifo_data  <= sdram_data;
            end

            if (restart_ok && restart) begin
                row             <= '0;
                burst_cnt       <= '0;
                line_cnt        <= '0;
                frame_done      <= 1'b0;
                restart_pending <= 1'b0;
                state           <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (free_space >= {1'b0, next_len}) begin
                            burst_length  <= next_len;
                            burst_address <= req_addr;
                            rd_req        <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                    RD_REQ: begin
                        if (vs_neg) restart_pending <= 1'b1;
                        if (rd_ack) begin
                            rd_req    <= 1'b0;
                            remaining <= burst_length;
                            state     <= BURST;
                        end
                    end
                    BURST: begin
                        if (vs_neg) restart_pending <= 1'b1;
                        if (rd_data_valid) begin
                            remaining <= remaining - 9'd1;
                            if (remaining == 9'd1) state <= STATE_NOP;
                        end
                    end
                    STATE_NOP: begin
                        row       <= row + 14'd1;
                        burst_cnt <= burst_cnt + 2'd1;
                        state     <= IDLE;
                        if (burst_cnt == 2'd3) begin
                            line_cnt <= line_cnt + 9'd1;
                            if ((line_cnt + 9'd1) == LPF_W) begin
                                frame_done <= 1'b1;
                                state      <= FRAME_DONE;
                            end
                        end
                    end
                    FRAME_DONE: begin
                        state <= FRAME_DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rd_sdram.sv
// Directed bench for rd_sdram: scoreboard of returned SDRAM words against FIFO writes,
// plus request address/length, backpressure and frame-restart checks (two lines per frame).
module tb_rd_sdram;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_neg;
    logic        field;
    logic [8:0]  wrusedw_fifo;
    logic        wr_en_fifo;
    logic [15:0] fifo_data;
    logic        rd_req;
    logic        rd_ack;
    logic        rd_data_valid;
    logic [15:0] sdram_data;
    logic [8:0]  burst_length;
    logic [21:0] burst_address;
    logic        frame_done;

    int          n_vec  = 0;
    int          n_err  = 0;
    int          wr_cnt = 0;
    logic [15:0] exp_q[$];

    rd_sdram #(.LINES_PER_FRAME(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .vs_neg        (vs_neg),
        .field         (field),
        .wrusedw_fifo  (wrusedw_fifo),
        .wr_en_fifo    (wr_en_fifo),
        .fifo_data     (fifo_data),
        .rd_req        (rd_req),
        .rd_ack        (rd_ack),
        .rd_data_valid (rd_data_valid),
        .sdram_data    (sdram_data),
        .burst_length  (burst_length),
        .burst_address (burst_address),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] exp_addr(input logic [13:0] row);
`ifdef RD_FIELD_OFFSET_EN
        return field ? {row, 8'h00} : ({row, 8'h00} + 22'h200000);
`else
        return {row, 8'h00};
`endif
    endfunction

    // Every valid word driven must appear on the FIFO port exactly one edge later.
    always @(posedge clk) begin
        logic        exp_en;
        logic [15:0] exp_d;
        exp_en = rd_data_valid && !reset;
        #1;
        chk("wr_en_fifo", 32'(wr_en_fifo), 32'(exp_en));
        if (wr_en_fifo) wr_cnt++;
        if (exp_en) begin
            if (exp_q.size() != 0) begin
                exp_d = exp_q.pop_front();
                chk("fifo_data", 32'(fifo_data), 32'(exp_d));
            end else begin
                chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
            end
        end
    end

    task automatic get_req(input string tag, input logic [21:0] a, input logic [8:0] len, input bit vs_with_ack);
        int i;
        i = 0;
        while (rd_req !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_req"}, 32'(rd_req), 32'd1);
        chk({tag, "_addr"}, 32'(burst_address), 32'(a));
        chk({tag, "_len"}, 32'(burst_length), 32'(len));
        @(negedge clk);
        chk({tag, "_hold"}, {rd_req, burst_length, burst_address}, {1'b1, len, a});
        rd_ack = 1'b1;
        vs_neg = vs_with_ack;
        @(negedge clk);
        rd_ack = 1'b0;
        vs_neg = 1'b0;
        chk({tag, "_drop"}, 32'(rd_req), 32'd0);
    endtask

    task automatic stream(input string tag, input int n, input bit gaps, input int vs_at);
        int sent;
        int start;
        sent  = 0;
        start = wr_cnt;
        while (sent < n) begin
            vs_neg = 1'b0;
            if (!gaps || $urandom_range(0, 2) != 0) begin
                rd_data_valid = 1'b1;
                sdram_data    = 16'($urandom);
                exp_q.push_back(sdram_data);
                if (sent == vs_at) vs_neg = 1'b1;
                sent++;
            end else begin
                rd_data_valid = 1'b0;
            end
            @(negedge clk);
        end
        rd_data_valid = 1'b0;
        vs_neg        = 1'b0;
        chk({tag, "_writes"}, 32'(wr_cnt - start), 32'(n));
    endtask

    initial begin
        int  line_start;
        bit  seen;
        int  i;
        reset         = 1'b1;
        vs_neg        = 1'b0;
        field         = 1'b0;
        wrusedw_fifo  = 9'd0;
        rd_ack        = 1'b0;
        rd_data_valid = 1'b0;
        sdram_data    = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_wr_en", 32'(wr_en_fifo), 32'd0);
        chk("rst_fifo_data", 32'(fifo_data), 32'd0);
        chk("rst_len", 32'(burst_length), 32'd0);
        chk("rst_addr", 32'(burst_address), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;

        // reset in the middle of a burst
        get_req("first", exp_addr(14'd0), 9'd256, 1'b0);
        stream("pre_reset", 50, 1'b0, -1);
        reset = 1'b1;
        #1;
        chk("midrst_rd_req", 32'(rd_req), 32'd0);
        chk("midrst_wr_en", 32'(wr_en_fifo), 32'd0);
        chk("midrst_fifo_data", 32'(fifo_data), 32'd0);
        chk("midrst_len", 32'(burst_length), 32'd0);
        chk("midrst_addr", 32'(burst_address), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // line 0: four bursts, no backpressure
        line_start = wr_cnt;
        for (int b = 0; b < 4; b++) begin
            get_req($sformatf("l0b%0d", b), exp_addr(14'(b)), (b == 3) ? 9'd32 : 9'd256, 1'b0);
            stream($sformatf("l0b%0d", b), (b == 3) ? 32 : 256, 1'b0, -1);
        end
        chk("line0_words", 32'(wr_cnt - line_start), 32'd800);

        // line 1: backpressure on a long burst, gaps, exact-fit short burst
        wrusedw_fifo = 9'd300;
        repeat (20) @(negedge clk);
        chk("bp_long_norq", 32'(rd_req), 32'd0);
        wrusedw_fifo = 9'd0;
        get_req("l1b0", exp_addr(14'd4), 9'd256, 1'b0);
        stream("l1b0", 256, 1'b0, -1);
        get_req("l1b1", exp_addr(14'd5), 9'd256, 1'b0);
        stream("l1b1_gaps", 256, 1'b1, -1);
        get_req("l1b2", exp_addr(14'd6), 9'd256, 1'b0);
        stream("l1b2", 256, 1'b0, -1);
        wrusedw_fifo = 9'd481;
        repeat (20) @(negedge clk);
        chk("bp_short_norq", 32'(rd_req), 32'd0);
        wrusedw_fifo = 9'd480;
        get_req("l1b3", exp_addr(14'd7), 9'd32, 1'b0);
        wrusedw_fifo = 9'd0;
        stream("l1b3", 32, 1'b0, -1);

        // frame complete after two lines
        i = 0;
        while (frame_done !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("frame_done_set", 32'(frame_done), 32'd1);
        seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (rd_req === 1'b1) seen = 1'b1;
        end
        chk("fd_no_req", 32'(seen), 32'd0);
        chk("fd_held", 32'(frame_done), 32'd1);

        vs_neg = 1'b1;
        field  = 1'b1;
        @(negedge clk);
        vs_neg = 1'b0;
        chk("fd_clear", 32'(frame_done), 32'd0);
        get_req("restart_f1", exp_addr(14'd0), 9'd256, 1'b0);
        field = 1'b0;

        // frame start during a burst: burst completes, then restart at row 0
        stream("vs_mid", 256, 1'b0, 100);
        get_req("after_vs", exp_addr(14'd0), 9'd256, 1'b1);
        stream("vs_ack", 256, 1'b1, -1);
        get_req("after_vs_ack", exp_addr(14'd0), 9'd256, 1'b0);
        stream("normal", 256, 1'b0, -1);
        get_req("next_row", exp_addr(14'd1), 9'd256, 1'b0);
        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
